// File: rtl/lif_layer_scheduler.sv
// rtl/lif_layer_scheduler.sv - time-multiplexes one shared LIF neuron datapath across a layer
// Holds weights, membrane state, spike flags and config; sweeps one neuron per cycle on each step.
module lif_layer_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int N_STAGES  = 5,
  localparam int INPUTS = 2**N_STAGES,
  localparam int OP     = N_STAGES + 2,
  localparam int W      = N_NEURONS * INPUTS,
  localparam int IDX_W  = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [1:0]           cfg_sel,
  input  logic [7:0]           cfg_data,
  output logic                 cfg_ready,
  input  logic                 step,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spikes,
  output logic [INPUTS-1:0]    dp_w,
  output logic [INPUTS-1:0]    dp_x,
  output logic [2:0]           dp_shift,
  output logic [OP-1:0]        dp_prev_u,
  output logic [OP-1:0]        dp_minus_teta,
  output logic                 dp_was_spike,
  input  logic [OP-1:0]        dp_u_out,
  input  logic                 dp_is_spike
);

  typedef enum logic {IDLE, EVAL} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         wbank;
  logic [INPUTS-1:0]    x;
  logic [OP-1:0]        u [N_NEURONS];
  logic [N_NEURONS-1:0] ws, ws_next;
  logic [2:0]           shift_q;
  logic [OP-1:0]        mteta;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [N_NEURONS-1:0] spikes_q;
  logic                 busy_q, done_q;
  logic                 last, cfg_we;

  assign cfg_ready = !busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spikes    = spikes_q;
  assign cfg_we    = cfg_valid && !busy_q;

  assign dp_w          = wbank[idx*INPUTS +: INPUTS];
  assign dp_x          = x;
  assign dp_shift      = shift_q;
  assign dp_prev_u     = u[idx];
  assign dp_minus_teta = mteta;
  assign dp_was_spike  = ws[idx];

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (step) state_d = EVAL;
      end
      EVAL: begin
        last = (idx == IDX_W'(N_NEURONS - 1));
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // spike vector including the neuron being evaluated this cycle
  always_comb begin
    ws_next      = ws;
    ws_next[idx] = dp_is_spike;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wbank    <= '1;
      x        <= '0;
      for (int k = 0; k < N_NEURONS; k++) u[k] <= '0;
      ws       <= '0;
      shift_q  <= '0;
      mteta    <= OP'(-5);
      idx      <= '0;
      spikes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      busy_q  <= (state_d == EVAL);
      // done is registered so it lands on the cycle the last neuron is presented
      done_q  <= (state_d == EVAL) && (idx_d == IDX_W'(N_NEURONS - 1));
      if (state_q == EVAL) begin
        u[idx] <= dp_u_out;
        ws     <= ws_next;
        if (last) spikes_q <= ws_next;
      end
      if (cfg_we) begin
        case (cfg_sel)
          2'b00: x       <= {x[INPUTS-9:0], cfg_data};
          2'b01: wbank   <= {wbank[W-9:0], cfg_data};
          2'b10: shift_q <= cfg_data[2:0];
          2'b11: mteta   <= cfg_data[OP-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// tb/tb_lif_layer_scheduler.sv - self-checking bench for lif_layer_scheduler with a stub datapath
module tb_lif_layer_scheduler;
  localparam int N = 4;
  localparam int NS = 5;
  localparam int IN = 32;
  localparam int OP = 7;

  logic clk = 0, reset = 1;
  logic cfg_valid = 0;
  logic [1:0] cfg_sel = 0;
  logic [7:0] cfg_data = 0;
  logic cfg_ready, step = 0, busy, done;
  logic [N-1:0] spikes;
  logic [IN-1:0] dp_w, dp_x;
  logic [2:0] dp_shift;
  logic [OP-1:0] dp_prev_u, dp_minus_teta, dp_u_out;
  logic dp_was_spike, dp_is_spike;

  assign dp_u_out    = dp_prev_u + 7'd1;
  assign dp_is_spike = dp_w[0];

  lif_layer_scheduler #(.N_NEURONS(N), .N_STAGES(NS)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .step(step), .busy(busy), .done(done), .spikes(spikes),
    .dp_w(dp_w), .dp_x(dp_x), .dp_shift(dp_shift), .dp_prev_u(dp_prev_u),
    .dp_minus_teta(dp_minus_teta), .dp_was_spike(dp_was_spike),
    .dp_u_out(dp_u_out), .dp_is_spike(dp_is_spike));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  int done_seen = 0, last_done_cyc = 0;

  // reference model of the layer state
  logic [N*IN-1:0] m_wb;
  logic [IN-1:0]   m_x;
  logic [OP-1:0]   m_u [N];
  logic [N-1:0]    m_ws, m_spikes;
  logic [2:0]      m_shift;
  logic [OP-1:0]   m_mteta;

  task automatic model_reset();
    m_wb = '1; m_x = '0; m_ws = '0; m_spikes = '0; m_shift = '0; m_mteta = 7'h7B;
    for (int k = 0; k < N; k++) m_u[k] = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] d);
    cfg_valid = 1; cfg_sel = sel; cfg_data = d;
    tick();
    cfg_valid = 0;
    case (sel)
      2'b00: m_x = (m_x << 8) | IN'(d);
      2'b01: m_wb = (m_wb << 8) | (N*IN)'(d);
      2'b10: m_shift = d[2:0];
      default: m_mteta = d[OP-1:0];
    endcase
  endtask

  // one timestep; checks every presented operand and the final spike vector
  task automatic run_sweep(input bit hold_step, input bit cfg_mid, input bit cfg_start);
    logic [IN-1:0] wk;
    step = 1;
    if (cfg_start) begin
      cfg_valid = 1; cfg_sel = 2'b00; cfg_data = 8'hAA;
      m_x = (m_x << 8) | IN'(8'hAA);
    end
    tick();
    cfg_valid = 0;
    if (!hold_step) step = 0;
    for (int k = 0; k < N; k++) begin
      wk = m_wb[k*IN +: IN];
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL busy k=%0d got %b exp 1", k, busy); end
      n_checks++; if (cfg_ready !== 1'b0) begin n_errors++; $display("FAIL cfg_ready_eval k=%0d got %b exp 0", k, cfg_ready); end
      n_checks++; if (done !== (k == N-1)) begin n_errors++; $display("FAIL done k=%0d got %b exp %b", k, done, (k == N-1)); end
      n_checks++; if (dp_w !== wk) begin n_errors++; $display("FAIL dp_w k=%0d got %h exp %h", k, dp_w, wk); end
      n_checks++; if (dp_prev_u !== m_u[k]) begin n_errors++; $display("FAIL dp_prev_u k=%0d got %h exp %h", k, dp_prev_u, m_u[k]); end
      n_checks++; if (dp_was_spike !== m_ws[k]) begin n_errors++; $display("FAIL dp_was_spike k=%0d got %b exp %b", k, dp_was_spike, m_ws[k]); end
      n_checks++; if (dp_x !== m_x) begin n_errors++; $display("FAIL dp_x k=%0d got %h exp %h", k, dp_x, m_x); end
      n_checks++; if (dp_shift !== m_shift || dp_minus_teta !== m_mteta) begin n_errors++; $display("FAIL dp_cfg k=%0d got %h/%h exp %h/%h", k, dp_shift, dp_minus_teta, m_shift, m_mteta); end
      if (cfg_start && k == 0) begin
        n_checks++; if (dp_x[7:0] !== 8'hAA) begin n_errors++; $display("FAIL dp_x_step_cfg got %h exp aa", dp_x[7:0]); end
      end
      if (done === 1'b1) begin done_seen++; last_done_cyc = cyc; end
      if (cfg_mid && k == 1) begin cfg_valid = 1; cfg_sel = 2'b00; cfg_data = 8'hAA; end
      else cfg_valid = 0;
      tick();
    end
    cfg_valid = 0;
    step = 0;
    for (int k = 0; k < N; k++) begin
      m_u[k] = m_u[k] + 7'd1;
      m_ws[k] = m_wb[k*IN];
    end
    m_spikes = m_ws;
    n_checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin n_errors++; $display("FAIL busy_fall got %b/%b exp 0/1", busy, cfg_ready); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL done_after got %b exp 0", done); end
    n_checks++; if (spikes !== m_spikes) begin n_errors++; $display("FAIL spikes got %b exp %b", spikes, m_spikes); end
  endtask

  task automatic test_reset();
    n_checks++; if (spikes !== '0) begin n_errors++; $display("FAIL rst_spikes got %b exp 0", spikes); end
    n_checks++; if (busy !== 0 || done !== 0) begin n_errors++; $display("FAIL rst_busy_done got %b/%b exp 0/0", busy, done); end
    n_checks++; if (dp_minus_teta !== 7'b1111011) begin n_errors++; $display("FAIL rst_mteta got %b exp 1111011", dp_minus_teta); end
    n_checks++; if (dp_w !== '1) begin n_errors++; $display("FAIL rst_dp_w got %h exp ffffffff", dp_w); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cfg_ready got %b exp 1", cfg_ready); end
    n_checks++; if (dp_x !== '0 || dp_prev_u !== '0 || dp_shift !== '0) begin n_errors++; $display("FAIL rst_dp got %h/%h/%h exp 0", dp_x, dp_prev_u, dp_shift); end
  endtask

  task automatic test_single_step();
    for (int i = 0; i < 16; i++) cfg_write(2'b01, 8'h00);
    cfg_write(2'b01, 8'h01);
    run_sweep(0, 0, 0);
    n_checks++; if (spikes !== 4'b0001) begin n_errors++; $display("FAIL single_spikes got %b exp 0001", spikes); end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    done_seen = 0;
    run_sweep(0, 0, 0); d0 = last_done_cyc;
    run_sweep(0, 0, 0); d1 = last_done_cyc;
    n_checks++; if (d1 - d0 !== 5) begin n_errors++; $display("FAIL b2b_gap1 got %0d exp 5", d1 - d0); end
    run_sweep(0, 0, 0);
    n_checks++; if (last_done_cyc - d1 !== 5) begin n_errors++; $display("FAIL b2b_gap2 got %0d exp 5", last_done_cyc - d1); end
    n_checks++; if (done_seen !== 3) begin n_errors++; $display("FAIL b2b_done_count got %0d exp 3", done_seen); end
    for (int k = 0; k < N; k++) begin
      n_checks++; if (m_u[k] !== 7'd4) begin n_errors++; $display("FAIL b2b_model_u k=%0d got %0d exp 4", k, m_u[k]); end
    end
  endtask

  task automatic test_cfg_during_eval();
    run_sweep(0, 1, 0);
    n_checks++; if (dp_x !== m_x) begin n_errors++; $display("FAIL cfg_eval_x got %h exp %h", dp_x, m_x); end
    run_sweep(0, 0, 1);
  endtask

  task automatic test_step_held();
    done_seen = 0;
    run_sweep(1, 0, 0);
    tick();
    n_checks++; if (busy !== 1'b0 || done_seen !== 1) begin n_errors++; $display("FAIL step_held got busy=%b dones=%0d exp 0/1", busy, done_seen); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) cfg_write(2'b01, 8'($urandom));
      for (int i = 0; i < 4; i++) cfg_write(2'b00, 8'($urandom));
      cfg_write(2'b10, 8'($urandom));
      cfg_write(2'b11, 8'($urandom));
      n_checks++; if (dp_shift !== m_shift || dp_minus_teta !== m_mteta) begin n_errors++; $display("FAIL rand_cfg got %h/%h exp %h/%h", dp_shift, dp_minus_teta, m_shift, m_mteta); end
      for (int s = 0; s < 1 + int'($urandom_range(1, 0)); s++) run_sweep(0, 0, 0);
    end
  endtask

  task automatic test_reset_mid_eval();
    step = 1; tick(); step = 0;
    tick();
    reset = 1; tick(); reset = 0;
    model_reset();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy got %b/%b exp 0/0", busy, done); end
    n_checks++; if (spikes !== '0) begin n_errors++; $display("FAIL mid_rst_spikes got %b exp 0", spikes); end
    n_checks++; if (dp_minus_teta !== 7'h7B || dp_w !== '1) begin n_errors++; $display("FAIL mid_rst_cfg got %h/%h exp 7b/ffffffff", dp_minus_teta, dp_w); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mid_rst_done got %b exp 0", done); end
    run_sweep(0, 0, 0);
  endtask

  initial begin
    model_reset();
    tick(); tick();
    reset = 0;
    test_reset();
    test_single_step();
    test_back_to_back();
    test_cfg_during_eval();
    test_step_held();
    test_random();
    test_reset_mid_eval();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
